frame_buffer_arbiter: RTL
=========================

Name: frame_buffer_arbiter

Overview:
- Parametrised successor to the single-image VGA/processor RAM front end.
- Shares one single-port frame RAM between the VGA scan-out path and the processor.
- Generates scan-out addresses from pix_x/pix_y with window offset and power-of-two pixel replication.
- Double-buffers NUM_BANKS images with tear-free bank switching at frame start; arbitrates processor reads/writes with a req/ready handshake into cycles the display does not need.

Parameters:
- DATA_W, 32, RAM word width.
- ADDR_W, 15, RAM address width.
- IMG_W, 100, image width in pixels.
- IMG_H, 100, image height in pixels.
- NUM_BANKS, 2, number of stored images; NUM_BANKS*IMG_W*IMG_H <= 2^ADDR_W.
- X_OFF, 0, screen x of the image's left column.
- Y_OFF, 0, screen y of the image's top row.
- SCALE_LOG2, 0, pixel replication of 2^SCALE_LOG2 in both axes (0..2).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-low.
- pix_x  in  10  VGA current column.
- pix_y  in  10  VGA current row.
- bank_sel  in  $clog2(NUM_BANKS)  requested display bank.
- pix_data  out  DATA_W  pixel word for the display.
- pix_valid  out  1  pix_data belongs to the image window.
- frame_start  out  1  one-cycle pulse when pix_x==0 && pix_y==0 is sampled.
- disp_bank  out  $clog2(NUM_BANKS)  bank currently being displayed.
- cpu_req  in  1  processor access request; held until granted.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  absolute RAM address.
- cpu_wdata  in  DATA_W  write data.
- cpu_ready  out  1  one-cycle grant pulse.
- cpu_rdata  out  DATA_W  read data.
- cpu_rvalid  out  1  one-cycle pulse, cpu_rdata valid.
- mem_addr  out  ADDR_W  address to RAM.
- mem_wdata  out  DATA_W  write data to RAM.
- mem_wren  out  1  RAM write enable.
- mem_rdata  in  DATA_W  RAM read data, registered, 1-cycle latency.

Behaviour:
- Reset (rst=0, asynchronous):
  - All outputs 0, disp_bank=0, pipeline valid bits cleared.
  - Any in-flight cpu read is dropped with no cpu_rvalid; the processor re-presents from cpu_req, which it is still holding.
- Stage 1 (edge k): register in_win, the VGA address, and the frame-start flag.
  - in_win is set when X_OFF <= pix_x < X_OFF + (IMG_W<<SCALE_LOG2) and Y_OFF <= pix_y < Y_OFF + (IMG_H<<SCALE_LOG2).
  - VGA address = disp_bank*IMG_W*IMG_H + ((pix_y-Y_OFF)>>SCALE_LOG2)*IMG_W + ((pix_x-X_OFF)>>SCALE_LOG2).
  - Arithmetic is done at ADDR_W+2 bits and then truncated.
- Bank switch:
  - When pix_x==0 && pix_y==0 is sampled, disp_bank <= bank_sel and frame_start pulses in stage 1.
  - bank_sel is ignored at every other time.
  - The new bank applies from the next sampled pixel onward.
- Arbitration (combinational on stage-1 registers), strict VGA priority:
  - Stage-1 in_win=1: mem_addr = VGA address, mem_wren=0, cpu_ready=0.
  - Otherwise, if cpu_req=1: cpu_ready=1, mem_addr=cpu_addr, mem_wren=cpu_we, mem_wdata=cpu_wdata.
  - Otherwise: mem_wren=0, mem_addr holds its last value.
- CPU address range:
  - A cpu_addr >= NUM_BANKS*IMG_W*IMG_H is still granted.
  - On a write, mem_wren is forced to 0.
  - On a read, cpu_rdata=0 with cpu_rvalid asserted.
- Read return timing:
  - VGA: pix_data/pix_valid register mem_rdata at edge k+2, so there are 2 cycles of pixel latency from the edge that samples pix_x/pix_y. When stage-1 in_win=0, pix_valid=0 and pix_data=0.
  - CPU: cpu_rdata/cpu_rvalid register at the edge following the grant cycle + 1, i.e. 2 edges after the cpu_ready cycle. cpu_rvalid is a single pulse.
- Handshake rules:
  - cpu_req, cpu_we, cpu_addr and cpu_wdata must be stable while cpu_req=1 && cpu_ready=0.
  - The processor may issue back-to-back requests; a new grant is possible every cycle outside the window.
  - A request arriving in the same cycle the window ends is granted on the first out-of-window stage-1 cycle.
- Simultaneous grant and VGA: never; the arbitration is exclusive.
- There is no CPU starvation bound inside the window. Horizontal blanking guarantees service every line.

Test Plan:
- Reset values: hold rst=0 for 3 cycles with cpu_req=1 → all outputs 0 and no mem_wren. Release → first grant on the next out-of-window cycle.
- Scan-out with SCALE_LOG2=1, X_OFF=Y_OFF=0, bank 0, RAM preloaded with addr-as-data:
  - pix_x=5, pix_y=3 → 2 cycles later pix_valid=1 and pix_data=102.
  - pix_x=200 → pix_valid=0.
- Arbitration: cpu_req write addr 10, data 0xABCD while pix_x sweeps inside the window → cpu_ready stays 0. On the first pix_x out of window, cpu_ready pulses, mem_wren=1, mem_addr=10.
- CPU read: out of window, read addr 10 → cpu_rvalid pulses 2 cycles after cpu_ready with cpu_rdata=0xABCD.
- Bank switch: change bank_sel 0→1 mid-frame → disp_bank stays 0. At sampled (0,0), frame_start pulses and disp_bank=1. The next pixel (0,0) reads address 10000.
- Out of range: write addr 20000 → cpu_ready=1, mem_wren=0. Read addr 20000 → cpu_rdata=0, cpu_rvalid=1.

Source files
------------

// File: rtl/frame_buffer_arbiter.sv
// Shares one single-port frame RAM between VGA scan-out and a processor port.
// VGA owns the RAM whenever the registered pixel is inside the image window.
module frame_buffer_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 15,
  parameter int IMG_W      = 100,
  parameter int IMG_H      = 100,
  parameter int NUM_BANKS  = 2,
  parameter int X_OFF      = 0,
  parameter int Y_OFF      = 0,
  parameter int SCALE_LOG2 = 0,
  localparam int BANK_W    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [9:0]        pix_x,
  input  logic [9:0]        pix_y,
  input  logic [BANK_W-1:0] bank_sel,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_valid,
  output logic              frame_start,
  output logic [BANK_W-1:0] disp_bank,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ready,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int AW2        = ADDR_W + 2;
  localparam int WIN_W      = IMG_W << SCALE_LOG2;
  localparam int WIN_H      = IMG_H << SCALE_LOG2;
  localparam int BANK_WORDS = IMG_W * IMG_H;
  localparam int MEM_WORDS  = NUM_BANKS * BANK_WORDS;

  logic              in_win_p0;
  logic [AW2-1:0]    rel_x_p0, rel_y_p0;
  logic              cpu_in_range;

  logic              in_win_p1;
  logic [ADDR_W-1:0] vga_addr_p1;

  logic              vld_p2;
  logic              rd_vld_p2;
  logic              rd_oor_p2;

  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;

  // ---- stage 0: window test and address offsets from the raw VGA position
  always_comb begin
    in_win_p0 = (int'(pix_x) >= X_OFF) && (int'(pix_x) < X_OFF + WIN_W) &&
                (int'(pix_y) >= Y_OFF) && (int'(pix_y) < Y_OFF + WIN_H);
    rel_x_p0  = AW2'(pix_x) - AW2'(X_OFF);
    rel_y_p0  = AW2'(pix_y) - AW2'(Y_OFF);
  end

  assign cpu_in_range = AW2'(cpu_addr) < AW2'(MEM_WORDS);

  // ---- stage 1: registered window flag, address, frame start and bank
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_win_p1   <= 1'b0;
      frame_start <= 1'b0;
      disp_bank   <= '0;
    end else begin
      in_win_p1   <= in_win_p0;
      frame_start <= (pix_x == 10'd0) && (pix_y == 10'd0);
      // The address sampled with (0,0) still uses the old bank.
      if ((pix_x == 10'd0) && (pix_y == 10'd0))
        disp_bank <= bank_sel;
    end
  end

  always_ff @(posedge clk) begin
    vga_addr_p1 <= ADDR_W'(AW2'(disp_bank) * AW2'(BANK_WORDS) +
                           (rel_y_p0 >> SCALE_LOG2) * AW2'(IMG_W) +
                           (rel_x_p0 >> SCALE_LOG2));
  end

  // Strict VGA priority; the processor only gets cycles outside the window.
  always_comb begin
    cpu_ready = 1'b0;
    mem_wren  = 1'b0;
    mem_addr  = mem_addr_q;
    mem_wdata = mem_wdata_q;
    if (in_win_p1) begin
      mem_addr = vga_addr_p1;
    end else if (rst && cpu_req) begin
      cpu_ready = 1'b1;
      mem_addr  = cpu_addr;
      mem_wren  = cpu_we && cpu_in_range;
      mem_wdata = cpu_wdata;
    end
  end

  // ---- stage 2: RAM access in flight, remember who owns the returning word
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      vld_p2      <= 1'b0;
      rd_vld_p2   <= 1'b0;
      rd_oor_p2   <= 1'b0;
    end else begin
      mem_addr_q  <= mem_addr;
      mem_wdata_q <= mem_wdata;
      vld_p2      <= in_win_p1;
      rd_vld_p2   <= cpu_ready && !cpu_we;
      rd_oor_p2   <= !cpu_in_range;
    end
  end

  // ---- stage 3: RAM data routed to the display or the processor
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pix_valid  <= 1'b0;
      pix_data   <= '0;
      cpu_rvalid <= 1'b0;
      cpu_rdata  <= '0;
    end else begin
      pix_valid  <= vld_p2;
      pix_data   <= vld_p2 ? mem_rdata : '0;
      cpu_rvalid <= rd_vld_p2;
      cpu_rdata  <= (rd_vld_p2 && !rd_oor_p2) ? mem_rdata : '0;
    end
  end

endmodule
